omsp_hmac_seq: RTL and testbench

- Initiator-side sequencer that drives the HMAC engine's start_continue / data_available / busy handshake on behalf of the CPU.
- On a command it fetches a message of msg_len bytes from data memory and feeds it to the engine RATE bits at a time.
- It then closes the message, collects a TAG_SIZE-bit tag, and either writes the tag back to memory or compares it against a stored tag.
- Sits between the module-protection control logic and the HMAC engine; owns a single byte-wide memory port.

---
 rtl/omsp_hmac_seq_pkg.sv | 13 +
 rtl/omsp_hmac_seq.sv | 247 ++++++++++++++++++++++++
 tb/tb_omsp_hmac_seq.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/omsp_hmac_seq_pkg.sv
// Shared state encoding and tag geometry for the HMAC initiator sequencer.
package omsp_hmac_seq_pkg;

  localparam int HMAC_RATE     = 8;
  localparam int HMAC_TAG_SIZE = 128;
  localparam int TAG_BYTES     = HMAC_TAG_SIZE / HMAC_RATE;

  typedef enum logic [3:0] {
    IDLE, MSG_RD, MSG_FEED, MSG_WAIT, PAD, PAD_WAIT,
    TAG_CAP, TAG_WR, TAG_CMP, SQUEEZE, SQ_WAIT, DONE
  } state_e;

endpackage

// File: rtl/omsp_hmac_seq.sv
// HMAC initiator sequencer: absorbs a memory message, pads, squeezes a tag and
// writes or verifies it. Verify mode is built only with OMSP_HMAC_SEQ_VERIFY_EN.
module omsp_hmac_seq
  import omsp_hmac_seq_pkg::*;
#(
  parameter int RATE     = HMAC_RATE,
  parameter int TAG_SIZE = HMAC_TAG_SIZE,
  parameter int LEN_W    = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             cmd_start,
  input  logic             cmd_verify,
  input  logic [LEN_W-1:0] msg_addr,
  input  logic [LEN_W-1:0] msg_len,
  input  logic [LEN_W-1:0] tag_addr,
  output logic             busy,
  output logic             done,
  output logic             tag_ok,
  output logic [LEN_W-1:0] mem_addr,
  output logic             mem_rd,
  input  logic [7:0]       mem_rdata,
  output logic             mem_wr,
  output logic [7:0]       mem_wdata,
  output logic             hmac_start_continue,
  output logic             hmac_data_available,
  output logic [RATE-1:0]  hmac_data_in,
  input  logic [RATE-1:0]  hmac_data_out,
  input  logic             hmac_busy
);

  localparam int NB    = TAG_SIZE / RATE;
  localparam int IDX_W = (NB > 1) ? $clog2(NB) : 1;

  state_e             r_state, w_state;
  logic [LEN_W-1:0]   r_ptr, w_ptr, r_rem, w_rem, r_tbase, w_tbase;
  logic [IDX_W-1:0]   r_idx, w_idx;
  logic [RATE-1:0]    r_tbyte, w_tbyte;
  logic [7:0]         r_rbyte, w_rbyte;
  logic               r_rd_q, r_bvld, w_bvld, r_wait1, w_wait1;
  logic               r_busy, w_busy, r_done, w_done;
  logic [LEN_W-1:0]   r_mem_addr, w_mem_addr;
  logic               r_mem_rd, w_mem_rd, r_mem_wr, w_mem_wr;
  logic [7:0]         r_mem_wdata, w_mem_wdata;
  logic               r_start, w_start, r_dav, w_dav;
  logic [RATE-1:0]    r_din, w_din;
  logic               w_last;
`ifdef OMSP_HMAC_SEQ_VERIFY_EN
  logic               r_verify, w_verify, r_match, w_match, r_tag_ok, w_tag_ok;
`else
  logic               w_unused;
  assign w_unused = cmd_verify;
`endif

  assign w_last = (r_idx == IDX_W'(NB - 1));

  always_comb begin
    w_state     = r_state;
    w_ptr       = r_ptr;
    w_rem       = r_rem;
    w_tbase     = r_tbase;
    w_idx       = r_idx;
    w_tbyte     = r_tbyte;
    // A read launched two cycles back lands here; hold it until consumed.
    w_rbyte     = r_rd_q ? mem_rdata : r_rbyte;
    w_bvld      = r_bvld | r_rd_q;
    w_wait1     = 1'b0;
    w_busy      = r_busy;
    w_done      = 1'b0;
    w_mem_addr  = r_mem_addr;
    w_mem_rd    = 1'b0;
    w_mem_wr    = 1'b0;
    w_mem_wdata = r_mem_wdata;
    w_start     = 1'b0;
    w_dav       = r_dav;
    w_din       = r_din;
`ifdef OMSP_HMAC_SEQ_VERIFY_EN
    w_verify    = r_verify;
    w_match     = r_match;
    w_tag_ok    = r_tag_ok;
`endif
    case (r_state)
      IDLE: begin
        // The done cycle already shows IDLE; a start there is dropped.
        if (cmd_start && !r_done) begin
          w_ptr   = msg_addr;
          w_rem   = msg_len;
          w_tbase = tag_addr;
          w_busy  = 1'b1;
`ifdef OMSP_HMAC_SEQ_VERIFY_EN
          w_verify = cmd_verify;
          w_match  = 1'b1;
          w_tag_ok = 1'b0;
`endif
          w_state = (msg_len != '0) ? MSG_RD : PAD;
        end
      end
      MSG_RD: begin
        w_mem_rd   = 1'b1;
        w_mem_addr = r_ptr;
        w_bvld     = 1'b0;
        w_state    = MSG_FEED;
      end
      MSG_FEED: begin
        if (r_bvld && !hmac_busy) begin
          w_start = 1'b1;
          w_dav   = 1'b1;
          w_din   = RATE'(r_rbyte);
          w_bvld  = 1'b0;
          w_wait1 = 1'b1;
          w_ptr   = r_ptr + 1'b1;
          w_rem   = r_rem - 1'b1;
          w_state = MSG_WAIT;
        end
      end
      MSG_WAIT: begin
        if (!r_wait1 && !hmac_busy) w_state = (r_rem != '0) ? MSG_RD : PAD;
      end
      PAD, SQUEEZE: begin
        if (!hmac_busy) begin
          w_start = 1'b1;
          w_dav   = 1'b0;
          w_wait1 = 1'b1;
          w_state = (r_state == PAD) ? PAD_WAIT : SQ_WAIT;
        end
      end
      PAD_WAIT: begin
        if (!r_wait1 && !hmac_busy) begin
          w_idx   = '0;
          w_state = TAG_CAP;
        end
      end
      SQ_WAIT: begin
        if (!r_wait1 && !hmac_busy) w_state = TAG_CAP;
      end
      TAG_CAP: begin
        w_tbyte = hmac_data_out;
        w_state = TAG_WR;
`ifdef OMSP_HMAC_SEQ_VERIFY_EN
        if (r_verify) begin
          w_mem_rd   = 1'b1;
          w_mem_addr = r_tbase + LEN_W'(r_idx);
          w_bvld     = 1'b0;
          w_state    = TAG_CMP;
        end
`endif
      end
      TAG_WR: begin
        w_mem_wr    = 1'b1;
        w_mem_addr  = r_tbase + LEN_W'(r_idx);
        w_mem_wdata = 8'(r_tbyte);
        w_idx       = w_last ? r_idx : r_idx + 1'b1;
        w_state     = w_last ? DONE : SQUEEZE;
      end
`ifdef OMSP_HMAC_SEQ_VERIFY_EN
      TAG_CMP: begin
        // No early exit on mismatch so verify time is data independent.
        if (r_bvld) begin
          w_match = r_match & (r_rbyte == 8'(r_tbyte));
          w_bvld  = 1'b0;
          w_idx   = w_last ? r_idx : r_idx + 1'b1;
          w_state = w_last ? DONE : SQUEEZE;
        end
      end
`endif
      DONE: begin
        w_done  = 1'b1;
        w_busy  = 1'b0;
`ifdef OMSP_HMAC_SEQ_VERIFY_EN
        w_tag_ok = r_verify & r_match;
`endif
        w_state = IDLE;
      end
      default: w_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= IDLE;
      r_ptr       <= '0;
      r_rem       <= '0;
      r_tbase     <= '0;
      r_idx       <= '0;
      r_tbyte     <= '0;
      r_rbyte     <= '0;
      r_rd_q      <= 1'b0;
      r_bvld      <= 1'b0;
      r_wait1     <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_rd    <= 1'b0;
      r_mem_wr    <= 1'b0;
      r_mem_wdata <= '0;
      r_start     <= 1'b0;
      r_dav       <= 1'b0;
      r_din       <= '0;
`ifdef OMSP_HMAC_SEQ_VERIFY_EN
      r_verify    <= 1'b0;
      r_match     <= 1'b0;
      r_tag_ok    <= 1'b0;
`endif
    end else begin
      r_state     <= w_state;
      r_ptr       <= w_ptr;
      r_rem       <= w_rem;
      r_tbase     <= w_tbase;
      r_idx       <= w_idx;
      r_tbyte     <= w_tbyte;
      r_rbyte     <= w_rbyte;
      r_rd_q      <= r_mem_rd;
      r_bvld      <= w_bvld;
      r_wait1     <= w_wait1;
      r_busy      <= w_busy;
      r_done      <= w_done;
      r_mem_addr  <= w_mem_addr;
      r_mem_rd    <= w_mem_rd;
      r_mem_wr    <= w_mem_wr;
      r_mem_wdata <= w_mem_wdata;
      r_start     <= w_start;
      r_dav       <= w_dav;
      r_din       <= w_din;
`ifdef OMSP_HMAC_SEQ_VERIFY_EN
      r_verify    <= w_verify;
      r_match     <= w_match;
      r_tag_ok    <= w_tag_ok;
`endif
    end
  end

  assign busy                = r_busy;
  assign done                = r_done;
  assign mem_addr            = r_mem_addr;
  assign mem_rd              = r_mem_rd;
  assign mem_wr              = r_mem_wr;
  assign mem_wdata           = r_mem_wdata;
  assign hmac_start_continue = r_start;
  assign hmac_data_available = r_dav;
  assign hmac_data_in        = r_din;
`ifdef OMSP_HMAC_SEQ_VERIFY_EN
  assign tag_ok = r_tag_ok;
`else
  assign tag_ok = 1'b0;
`endif

endmodule

// File: tb/tb_omsp_hmac_seq.sv
// Directed bench for omsp_hmac_seq with a byte memory and a toy engine model
// (tag byte k = running rotate-xor digest of the message + 37*k).
module tb_omsp_hmac_seq;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        cmd_start, cmd_verify;
  logic [15:0] msg_addr, msg_len, tag_addr;
  logic        busy, done, tag_ok;
  logic [15:0] mem_addr;
  logic        mem_rd, mem_wr;
  logic [7:0]  mem_rdata, mem_wdata;
  logic        hmac_start_continue, hmac_data_available;
  logic [7:0]  hmac_data_in, hmac_data_out;
  logic        hmac_busy;

  always #5 clk = ~clk;

  omsp_hmac_seq dut (
    .clk(clk), .reset_n(reset_n), .cmd_start(cmd_start), .cmd_verify(cmd_verify),
    .msg_addr(msg_addr), .msg_len(msg_len), .tag_addr(tag_addr),
    .busy(busy), .done(done), .tag_ok(tag_ok),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_rdata(mem_rdata),
    .mem_wr(mem_wr), .mem_wdata(mem_wdata),
    .hmac_start_continue(hmac_start_continue), .hmac_data_available(hmac_data_available),
    .hmac_data_in(hmac_data_in), .hmac_data_out(hmac_data_out), .hmac_busy(hmac_busy)
  );

  int n_chk = 0, n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  // memory: single writer process; the bench pokes through tb_wen
  logic [7:0]  mem [0:65535];
  logic        tb_wen = 1'b0;
  logic [15:0] tb_waddr = '0;
  logic [7:0]  tb_wdat = '0;
  always @(posedge clk) begin
    if (mem_rd) mem_rdata <= mem[mem_addr];
    if (mem_wr) mem[mem_addr] <= mem_wdata;
    if (tb_wen) mem[tb_waddr] <= tb_wdat;
  end

  // engine model and protocol monitors
  logic       tb_clr = 1'b1;
  int         busy_len = 1;
  int         e_bcnt;
  logic [7:0] e_acc;
  bit         e_pad;
  int         e_k;
  int         n_abs, n_pad, n_sq, n_wr, n_rdm, n_rdt, n_done, n_viol;
  logic [23:0] abs_log;
  assign hmac_busy = (e_bcnt != 0);

  always @(posedge clk) begin
    if (tb_clr) begin
      e_bcnt <= 0; hmac_data_out <= '0;
      e_acc = 8'hA5; e_pad = 0; e_k = 0; abs_log = '0;
      n_abs = 0; n_pad = 0; n_sq = 0; n_wr = 0; n_rdm = 0; n_rdt = 0; n_done = 0; n_viol = 0;
    end else begin
      if (hmac_start_continue) begin
        if (hmac_busy) n_viol++;
        e_bcnt <= busy_len;
        if (hmac_data_available) begin
          e_acc = {e_acc[6:0], e_acc[7]} ^ hmac_data_in;
          abs_log = {abs_log[15:0], hmac_data_in};
          n_abs++;
        end else begin
          if (!e_pad) begin e_pad = 1; e_k = 0; n_pad++; end
          else begin e_k++; n_sq++; end
          hmac_data_out <= e_acc + 8'(e_k * 37);
        end
      end else if (e_bcnt != 0) e_bcnt <= e_bcnt - 1;
      if (mem_rd && mem_wr) n_viol++;
      if (mem_rd) begin if (e_pad) n_rdt++; else n_rdm++; end
      if (mem_wr) n_wr++;
      if (done) n_done++;
    end
  end

  function automatic logic [7:0] exp_tag(input int nb, input logic [23:0] msg, input int k);
    logic [7:0] acc = 8'hA5;
    logic [23:0] t;
    for (int i = 0; i < nb; i++) begin
      t = msg >> (8 * (nb - 1 - i));
      acc = {acc[6:0], acc[7]} ^ t[7:0];
    end
    return acc + 8'(k * 37);
  endfunction

  task automatic tag_errs(input logic [15:0] a, input int nb, input logic [23:0] msg, output int e);
    e = 0;
    for (int k = 0; k < 16; k++) if (mem[16'(a + 16'(k))] !== exp_tag(nb, msg, k)) e++;
  endtask

  task automatic tick; @(posedge clk); #1; endtask
  task automatic clear; tb_clr = 1'b1; tick(); tb_clr = 1'b0; endtask
  task automatic poke(input logic [15:0] a, input logic [7:0] d);
    tb_wen = 1'b1; tb_waddr = a; tb_wdat = d; tick(); tb_wen = 1'b0;
  endtask

  task automatic issue(input logic v, input logic [15:0] ma, ml, ta);
    cmd_verify = v; msg_addr = ma; msg_len = ml; tag_addr = ta;
    cmd_start = 1'b1; tick(); cmd_start = 1'b0;
  endtask

  task automatic wait_done(output int cyc, output bit to);
    cyc = 1;
    while (!done && cyc < 4000) begin tick(); cyc++; end
    to = !done;
  endtask

  task automatic run_cmd(input logic v, input logic [15:0] ma, ml, ta, output int cyc, output bit to);
    issue(v, ma, ml, ta);
    wait_done(cyc, to);
    tick(); tick();
  endtask

  function automatic logic [63:0] outs();
    return {25'd0, busy, done, tag_ok, mem_rd, mem_wr, hmac_start_continue,
            hmac_data_available, mem_addr, mem_wdata, hmac_data_in};
  endfunction

  localparam logic [23:0] MSG = 24'h616263;
  int  cyc1, cyc5, cyc_a, cyc_b, errs;
  bit  to;

  initial begin
    reset_n = 1'b0; cmd_start = 1'b0; cmd_verify = 1'b0;
    msg_addr = '0; msg_len = '0; tag_addr = '0;
    repeat (3) tick();
    chk("reset_outs", outs(), 64'd0);
    reset_n = 1'b1;
    poke(16'h0200, 8'h61); poke(16'h0201, 8'h62); poke(16'h0202, 8'h63);

    // basic write-mode command, 1-cycle engine busy
    clear();
    run_cmd(1'b0, 16'h0200, 16'd3, 16'h0300, cyc1, to);
    chk("t1_timeout", 64'(to), 0);
    chk("t1_absorbs", 64'(n_abs), 3);
    chk("t1_abs_data", 64'(abs_log), 64'(MSG));
    chk("t1_pads", 64'(n_pad), 1);
    chk("t1_squeezes", 64'(n_sq), 15);
    chk("t1_writes", 64'(n_wr), 16);
    chk("t1_tag0", 64'(mem[16'h0300]), 64'h0F);
    chk("t1_tag15", 64'(mem[16'h030F]), 64'h3A);
    tag_errs(16'h0300, 3, MSG, errs);
    chk("t1_tag_errs", 64'(errs), 0);
    chk("t1_dones", 64'(n_done), 1);
    chk("t1_tag_ok", 64'(tag_ok), 0);
    chk("t1_proto", 64'(n_viol), 0);

    // same command, 5-cycle engine busy: 19 requests each cost 4 more cycles
    busy_len = 5;
    clear();
    run_cmd(1'b0, 16'h0200, 16'd3, 16'h0300, cyc5, to);
    chk("t2_timeout", 64'(to), 0);
    chk("t2_cyc_delta", 64'(cyc5 - cyc1), 76);
    chk("t2_proto", 64'(n_viol), 0);
    tag_errs(16'h0300, 3, MSG, errs);
    chk("t2_tag_errs", 64'(errs), 0);
    busy_len = 1;

    // empty message
    clear();
    run_cmd(1'b0, 16'h0200, 16'd0, 16'h0400, cyc_a, to);
    chk("t3_timeout", 64'(to), 0);
    chk("t3_msg_reads", 64'(n_rdm), 0);
    chk("t3_absorbs", 64'(n_abs), 0);
    chk("t3_writes", 64'(n_wr), 16);
    chk("t3_tag0", 64'(mem[16'h0400]), 64'hA5);
    tag_errs(16'h0400, 0, MSG, errs);
    chk("t3_tag_errs", 64'(errs), 0);

    // tag address wraps past 0xFFFF
    clear();
    run_cmd(1'b0, 16'h0200, 16'd3, 16'hFFF8, cyc_a, to);
    chk("t4_wrap_lo", 64'(mem[16'hFFF8]), 64'h0F);
    chk("t4_wrap_hi", 64'(mem[16'h0007]), 64'h3A);

`ifdef OMSP_HMAC_SEQ_VERIFY_EN
    for (int k = 0; k < 16; k++) poke(16'h0500 + 16'(k), exp_tag(3, MSG, k));
    clear();
    run_cmd(1'b1, 16'h0200, 16'd3, 16'h0500, cyc_a, to);
    chk("t5_timeout", 64'(to), 0);
    chk("t5_tag_ok", 64'(tag_ok), 1);
    chk("t5_writes", 64'(n_wr), 0);
    chk("t5_tag_reads", 64'(n_rdt), 16);
    poke(16'h050A, exp_tag(3, MSG, 10) ^ 8'h01);
    clear();
    run_cmd(1'b1, 16'h0200, 16'd3, 16'h0500, cyc_b, to);
    chk("t6_tag_ok", 64'(tag_ok), 0);
    chk("t6_tag_reads", 64'(n_rdt), 16);
    chk("t6_same_cycles", 64'(cyc_b), 64'(cyc_a));
`else
    clear();
    run_cmd(1'b1, 16'h0200, 16'd3, 16'h0500, cyc_a, to);
    chk("t5_writes", 64'(n_wr), 16);
    chk("t5_tag_ok", 64'(tag_ok), 0);
    tag_errs(16'h0500, 3, MSG, errs);
    chk("t5_tag_errs", 64'(errs), 0);
`endif

    // reset during squeeze phase
    clear();
    issue(1'b0, 16'h0200, 16'd3, 16'h0600);
    for (int i = 0; i < 2000 && n_sq < 3; i++) tick();
    chk("t7_reached_sq", 64'(n_sq >= 3), 1);
    #3 reset_n = 1'b0;
    #1 chk("t7_async_outs", outs(), 64'd0);
    repeat (4) tick();
    chk("t7_no_done", 64'(n_done), 0);
    reset_n = 1'b1;
    clear();
    run_cmd(1'b0, 16'h0200, 16'd3, 16'h0600, cyc_a, to);
    chk("t7_timeout", 64'(to), 0);
    tag_errs(16'h0600, 3, MSG, errs);
    chk("t7_tag_errs", 64'(errs), 0);
    chk("t7_dones", 64'(n_done), 1);

    // starts while busy and in the done cycle are dropped
    clear();
    issue(1'b0, 16'h0200, 16'd3, 16'h0700);
    repeat (8) tick();
    issue(1'b0, 16'h0200, 16'd0, 16'h0800);
    wait_done(cyc_a, to);
    chk("t8_timeout", 64'(to), 0);
    cmd_start = 1'b1; tick(); cmd_start = 1'b0;
    chk("t8_busy_after_done", 64'(busy), 0);
    repeat (6) tick();
    chk("t8_dones", 64'(n_done), 1);
    chk("t8_absorbs", 64'(n_abs), 3);
    chk("t8_still_idle", 64'(busy), 0);
    tag_errs(16'h0700, 3, MSG, errs);
    chk("t8_tag_errs", 64'(errs), 0);
    chk("t8_proto", 64'(n_viol), 0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
